// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg
// Shared definitions for the PLL reset sequencer: the sequencer state
// encoding, default timing constants and a counter-width helper.
// No ports (package).
package pll_rst_pkg;

  // Sequencer states: waiting for lock, qualifying lock, core released,
  // fully running.
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_QUAL = 2'd1,
    S_CORE = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int STAGE_GAP_DEF   = 16;
  localparam int PIX_DIV_DEF     = 5;

  // Bits needed to hold values 0..n-1.
  // Width is never allowed to drop below one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
// Multi-flop synchronizer for a single asynchronous bit. Reusable for any
// single-bit CDC crossing; the chain clears to 0 on reset.
// Ports:
//   clk_i   in  1  destination clock
//   rst_ni  in  1  asynchronous active-low clear
//   d_i     in  1  asynchronous input bit
//   q_o     out 1  synchronized bit (last stage of the chain)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the input through the chain; only the last stage is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq
// Runs on the PLL output clock. Synchronizes and qualifies the PLL locked
// flag, then releases the core/pixel reset followed, after a fixed gap, by
// the TMDS serializer reset. Lock loss re-asserts both resets and bumps a
// saturating debug counter.
// Optional feature macro: PIX_CE_EN enables the pixel clock-enable divider;
// without it pix_ce is tied to 0.
// Ports:
//   clock_in       in  1      PLL output clock
//   reset_n        in  1      asynchronous active-low reset
//   pll_locked     in  1      PLL locked flag, asynchronous to clock_in
//   rst_core       out 1      active-high sync reset, pixel pipeline
//   rst_tmds       out 1      active-high sync reset, TMDS serializer
//   ready          out 1      both resets released
//   lock_loss_cnt  out CNT_W  saturating count of lock-loss events
//   pix_ce         out 1      pixel clock enable, 1 of every PIX_DIV cycles
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int STAGE_GAP   = STAGE_GAP_DEF,
  parameter int CNT_W       = 8,
  parameter int PIX_DIV     = PIX_DIV_DEF
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             pll_locked,
  output logic             rst_core,
  output logic             rst_tmds,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic             pix_ce
);

  // One counter is shared by lock qualification and the stage gap, so it
  // is sized for the larger of the two.
  localparam int CW = cntWidth((LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP);
  localparam logic [CW-1:0] QualLast = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GapLast  = CW'(STAGE_GAP - 1);

  if (SYNC_STAGES < 2 || LOCK_CYCLES < 1 || STAGE_GAP < 1 || PIX_DIV < 2 || CNT_W < 1) begin : g_param_check
    $error("pll_rst_seq: illegal parameter value");
  end

  logic             lkSync;
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             rstCore_q;
  logic             rstTmds_q;
  logic             ready_q;
  logic [CNT_W-1:0] lossCnt_q;
  logic [CNT_W-1:0] lossCnt_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clock_in),
    .rst_ni(reset_n),
    .d_i   (pll_locked),
    .q_o   (lkSync)
  );

  // Saturating increment: holds at all-ones.
  assign lossCnt_d = (&lossCnt_q) ? lossCnt_q : lossCnt_q + 1'b1;

  // Sequencer. Outputs are registered alongside the state so each reset
  // changes exactly on the state transition that owns it.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      rstCore_q <= 1'b1;
      rstTmds_q <= 1'b1;
      ready_q   <= 1'b0;
      lossCnt_q <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          cnt_q     <= '0;
          rstCore_q <= 1'b1;
          rstTmds_q <= 1'b1;
          ready_q   <= 1'b0;
          if (lkSync) state_q <= S_QUAL;
        end
        S_QUAL: begin
          // Dropping lock here never counts as a loss: it was not qualified.
          if (!lkSync) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == QualLast) begin
            state_q   <= S_CORE;
            cnt_q     <= '0;
            rstCore_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CORE: begin
          if (!lkSync) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            rstCore_q <= 1'b1;
            rstTmds_q <= 1'b1;
            ready_q   <= 1'b0;
            lossCnt_q <= lossCnt_d;
          end else if (cnt_q == GapLast) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            rstTmds_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lkSync) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            rstCore_q <= 1'b1;
            rstTmds_q <= 1'b1;
            ready_q   <= 1'b0;
            lossCnt_q <= lossCnt_d;
          end
        end
        default: begin
          state_q   <= S_WAIT;
          cnt_q     <= '0;
          rstCore_q <= 1'b1;
          rstTmds_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_core      = rstCore_q;
  assign rst_tmds      = rstTmds_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lossCnt_q;

`ifdef PIX_CE_EN
  localparam int DW = cntWidth(PIX_DIV);
  localparam logic [DW-1:0] DivLast = DW'(PIX_DIV - 1);

  logic [DW-1:0] pixDiv_q;

  // Divider parks at 0 while the core is in reset, so the first enable
  // lands in the first cycle the core reset is low.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      pixDiv_q <= '0;
    end else if (rstCore_q || pixDiv_q == DivLast) begin
      pixDiv_q <= '0;
    end else begin
      pixDiv_q <= pixDiv_q + 1'b1;
    end
  end

  // Gated by the core reset so the enable drops in the same cycle the
  // reset re-asserts on lock loss.
  assign pix_ce = !rstCore_q && (pixDiv_q == '0);
`else
  assign pix_ce = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq
// Self-checking bench for pll_rst_seq with LOCK_CYCLES=8, STAGE_GAP=4,
// SYNC_STAGES=2, CNT_W=2, PIX_DIV=5. Honors PIX_CE_EN when defined.
module tb_pll_rst_seq;

  localparam int SYNC_STAGES = 2;
  localparam int LOCK_CYCLES = 8;
  localparam int STAGE_GAP   = 4;
  localparam int CNT_W       = 2;
  localparam int PIX_DIV     = 5;
  localparam int LAT_MIN     = SYNC_STAGES + LOCK_CYCLES - 1;
  localparam int LAT_MAX     = SYNC_STAGES + LOCK_CYCLES + 1;

  logic             clock_in;
  logic             reset_n;
  logic             pll_locked;
  logic             rst_core;
  logic             rst_tmds;
  logic             ready;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic             pix_ce;

  int checks = 0;
  int errors = 0;
  int orderViol = 0;

  // Scoreboard queues: expectations are pushed when stimulus is applied and
  // popped when the DUT produces the corresponding output.
  int lossQ[$];
  int gapQ[$];
  int pixQ[$];

  pll_rst_seq #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_CYCLES(LOCK_CYCLES),
    .STAGE_GAP  (STAGE_GAP),
    .CNT_W      (CNT_W),
    .PIX_DIV    (PIX_DIV)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .rst_core     (rst_core),
    .rst_tmds     (rst_tmds),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .pix_ce       (pix_ce)
  );

  // 100 MHz-ish free-running clock; only cycle counts matter here.
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Watch for the TMDS reset ever being released ahead of the core reset.
  always @(negedge clock_in) begin
    if (rst_tmds === 1'b0 && rst_core !== 1'b0) orderViol++;
  end

  task automatic applyReset();
    pll_locked = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  // Measures negedges until rst_core falls, then until rst_tmds falls;
  // flags ready rising before rst_tmds. Expired bounds give huge counts.
  task automatic measureRelease(output int coreLat, output int gapLat, output bit readyEarly);
    coreLat = 0;
    readyEarly = 1'b0;
    while (rst_core !== 1'b0 && coreLat < 200) begin
      @(negedge clock_in);
      coreLat++;
    end
    gapLat = 0;
    while (rst_tmds !== 1'b0 && gapLat < 100) begin
      if (ready !== 1'b0) readyEarly = 1'b1;
      @(negedge clock_in);
      gapLat++;
    end
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rst_core !== 1'b1) begin errors++; $display("[TB] FAIL reset_rst_core got %b expected 1", rst_core); end
    checks++; if (rst_tmds !== 1'b1) begin errors++; $display("[TB] FAIL reset_rst_tmds got %b expected 1", rst_tmds); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", ready); end
    checks++; if (lock_loss_cnt !== '0) begin errors++; $display("[TB] FAIL reset_loss_cnt got %0d expected 0", lock_loss_cnt); end
    checks++; if (pix_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_ce got %b expected 0", pix_ce); end
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  task automatic test_lock_release();
    int coreLat, gapLat;
    bit readyEarly;
    pll_locked = 1'b1;
    gapQ.push_back(STAGE_GAP);
    measureRelease(coreLat, gapLat, readyEarly);
    checks++; if (coreLat < LAT_MIN || coreLat > LAT_MAX) begin errors++; $display("[TB] FAIL release_latency got %0d expected %0d..%0d", coreLat, LAT_MIN, LAT_MAX); end
    checks++; if (gapLat !== gapQ[0] || readyEarly) begin errors++; $display("[TB] FAIL release_gap got %0d early_ready %0d expected %0d", gapLat, readyEarly, gapQ[0]); end
    void'(gapQ.pop_front());
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %b expected 1", ready); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL release_loss_cnt got %0d expected 0", lock_loss_cnt); end
  endtask

  task automatic test_glitch_restart();
    int coreLat, gapLat, early;
    bit readyEarly;
    applyReset();
    early = 0;
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_in);
      if (rst_core !== 1'b1) early++;
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_in);
      if (rst_core !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("[TB] FAIL glitch_no_release got %0d early cycles expected 0", early); end
    pll_locked = 1'b1;
    measureRelease(coreLat, gapLat, readyEarly);
    checks++; if (coreLat < LAT_MIN || coreLat > LAT_MAX) begin errors++; $display("[TB] FAIL glitch_relatency got %0d expected %0d..%0d", coreLat, LAT_MIN, LAT_MAX); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL glitch_loss_cnt got %0d expected 0", lock_loss_cnt); end
  endtask

  task automatic test_lock_loss();
    int lat, coreLat, gapLat;
    bit readyEarly;
    // Entered with the DUT in S_RUN and lock_loss_cnt at 0.
    lossQ.push_back(1);
    pll_locked = 1'b0;
    lat = 0;
    while (rst_core !== 1'b1 && lat < 20) begin
      @(negedge clock_in);
      lat++;
    end
    checks++; if (lat > SYNC_STAGES + 1) begin errors++; $display("[TB] FAIL loss_latency got %0d expected <=%0d", lat, SYNC_STAGES + 1); end
    checks++; if (rst_tmds !== 1'b1 || ready !== 1'b0) begin errors++; $display("[TB] FAIL loss_outputs got tmds %b ready %b expected tmds 1 ready 0", rst_tmds, ready); end
    checks++; if (lock_loss_cnt !== lossQ[0]) begin errors++; $display("[TB] FAIL loss_cnt got %0d expected %0d", lock_loss_cnt, lossQ[0]); end
    void'(lossQ.pop_front());
    pll_locked = 1'b1;
    measureRelease(coreLat, gapLat, readyEarly);
    checks++; if (coreLat < LAT_MIN || coreLat > LAT_MAX) begin errors++; $display("[TB] FAIL relock_latency got %0d expected %0d..%0d", coreLat, LAT_MIN, LAT_MAX); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL relock_ready got %b expected 1", ready); end
  endtask

  task automatic test_saturation();
    int coreLat, gapLat, lat, model;
    bit readyEarly;
    applyReset();
    model = 0;
    for (int ev = 0; ev < 4; ev++) begin
      pll_locked = 1'b1;
      measureRelease(coreLat, gapLat, readyEarly);
      checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL sat_ready_%0d got %b expected 1", ev, ready); end
      model = (model == (1 << CNT_W) - 1) ? model : model + 1;
      lossQ.push_back(model);
      pll_locked = 1'b0;
      lat = 0;
      while (rst_core !== 1'b1 && lat < 20) begin
        @(negedge clock_in);
        lat++;
      end
      @(negedge clock_in);
      checks++; if (lock_loss_cnt !== lossQ[0]) begin errors++; $display("[TB] FAIL sat_cnt_%0d got %0d expected %0d", ev, lock_loss_cnt, lossQ[0]); end
      void'(lossQ.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    int lat, coreLat, gapLat;
    bit readyEarly;
    // Entered with lock_loss_cnt saturated and pll_locked low.
    pll_locked = 1'b1;
    lat = 0;
    while (rst_core !== 1'b0 && lat < 200) begin
      @(negedge clock_in);
      lat++;
    end
    @(negedge clock_in);
    reset_n = 1'b0;
    #1;
    checks++; if (rst_core !== 1'b1 || rst_tmds !== 1'b1) begin errors++; $display("[TB] FAIL midrst_resets got core %b tmds %b expected 1 1", rst_core, rst_tmds); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready got %b expected 0", ready); end
    checks++; if (lock_loss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL midrst_loss_cnt got %0d expected 0", lock_loss_cnt); end
    checks++; if (pix_ce !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pix_ce got %b expected 0", pix_ce); end
    repeat (2) @(negedge clock_in);
    reset_n = 1'b1;
    gapQ.push_back(STAGE_GAP);
    measureRelease(coreLat, gapLat, readyEarly);
    checks++; if (coreLat < LAT_MIN || coreLat > LAT_MAX) begin errors++; $display("[TB] FAIL midrst_relatency got %0d expected %0d..%0d", coreLat, LAT_MIN, LAT_MAX); end
    checks++; if (gapLat !== gapQ[0] || readyEarly) begin errors++; $display("[TB] FAIL midrst_gap got %0d early_ready %0d expected %0d", gapLat, readyEarly, gapQ[0]); end
    void'(gapQ.pop_front());
  endtask

  task automatic test_pix_ce();
    int lat;
    applyReset();
    for (int i = 0; i < 12; i++) begin
`ifdef PIX_CE_EN
      pixQ.push_back((i % PIX_DIV) == 0 ? 1 : 0);
`else
      pixQ.push_back(0);
`endif
    end
    pll_locked = 1'b1;
    lat = 0;
    while (rst_core !== 1'b0 && lat < 200) begin
      @(negedge clock_in);
      lat++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock_in);
      checks++; if (pix_ce !== pixQ[0][0]) begin errors++; $display("[TB] FAIL pix_ce_cycle_%0d got %b expected %0d", i, pix_ce, pixQ[0]); end
      void'(pixQ.pop_front());
    end
    pll_locked = 1'b0;
    lat = 0;
    while (rst_core !== 1'b1 && lat < 20) begin
      @(negedge clock_in);
      lat++;
    end
    checks++; if (pix_ce !== 1'b0) begin errors++; $display("[TB] FAIL pix_ce_on_loss got %b expected 0", pix_ce); end
  endtask

  task automatic test_order();
    checks++; if (orderViol != 0) begin errors++; $display("[TB] FAIL reset_order got %0d violations expected 0", orderViol); end
  endtask

  initial begin
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_lock_release();
    test_lock_loss();
    test_glitch_restart();
    test_saturation();
    test_reset_mid();
    test_pix_ce();
    test_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
